// File: rtl/sram_data_responder.sv
// Bridges the CPU data-side SRAM-like port to AXI4-Lite-style read/write channels, one transaction at a time.
// Optional macro SRAM_RESP_POSTED_WRITE_EN: writes release the CPU once aw/w are accepted; bvalid is collected in the background.
module sram_data_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                data_sram_en,
  input  logic [DATA_W/8-1:0] data_sram_wen,
  input  logic [ADDR_W-1:0]   data_sram_addr,
  input  logic [DATA_W-1:0]   data_sram_wdata,
  output logic [DATA_W-1:0]   data_sram_rdata,
  output logic                dataStall,
  input  logic                pipelineStall,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(STRB_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t state;
  logic   aw_done;
  logic   w_done;
  logic   aw_fire;
  logic   w_fire;
  logic   wr_accepted;
  logic   can_launch;

`ifdef SRAM_RESP_POSTED_WRITE_EN
  logic wr_pending;
  // A new request may only launch once the previous posted write has its response.
  assign can_launch = ~wr_pending | bvalid;
`else
  assign can_launch = 1'b1;
`endif

  assign aw_fire     = awvalid & awready;
  assign w_fire      = wvalid & wready;
  assign wr_accepted = (aw_done | aw_fire) & (w_done | w_fire);

  assign dataStall = (state == IDLE) ? data_sram_en : (state != DONE);

  // Single sequential FSM; every bus-side output is a register so no valid depends on a ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      araddr          <= '0;
      arvalid         <= 1'b0;
      rready          <= 1'b0;
      awaddr          <= '0;
      awvalid         <= 1'b0;
      wdata           <= '0;
      wstrb           <= '0;
      wvalid          <= 1'b0;
      bready          <= 1'b0;
      data_sram_rdata <= '0;
`ifdef SRAM_RESP_POSTED_WRITE_EN
      wr_pending      <= 1'b0;
`endif
    end else begin
`ifdef SRAM_RESP_POSTED_WRITE_EN
      if (wr_pending && bvalid) begin
        wr_pending <= 1'b0;
        bready     <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          if (data_sram_en && can_launch) begin
            if (data_sram_wen == '0) begin
              araddr  <= data_sram_addr & WORD_MASK;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end else begin
              awaddr  <= data_sram_addr & WORD_MASK;
              wdata   <= data_sram_wdata;
              wstrb   <= data_sram_wen;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
              state   <= WR_REQ;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready          <= 1'b0;
            data_sram_rdata <= rdata;
            state           <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_fire) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_fire) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (wr_accepted) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
`ifdef SRAM_RESP_POSTED_WRITE_EN
            wr_pending <= 1'b1;
            state      <= DONE;
`else
            state      <= WR_RESP;
`endif
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            state  <= DONE;
          end
        end
        // Holding here under a pipeline stall keeps the still-asserted request from being reissued.
        DONE: begin
          if (!pipelineStall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_data_responder.sv
// Self-checking bench for sram_data_responder: directed vector table, hand-written corner sequences,
// and a randomized run against a memory-backed fabric model with a read-data scoreboard.
`timescale 1ns/1ps
module tb_sram_data_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        dataStall;
  logic        pipelineStall;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  sram_data_responder #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .dataStall       (dataStall),
    .pipelineStall   (pipelineStall),
    .araddr          (araddr),
    .arvalid         (arvalid),
    .arready         (arready),
    .rdata           (rdata),
    .rvalid          (rvalid),
    .rready          (rready),
    .awaddr          (awaddr),
    .awvalid         (awvalid),
    .awready         (awready),
    .wdata           (wdata),
    .wstrb           (wstrb),
    .wvalid          (wvalid),
    .wready          (wready),
    .bvalid          (bvalid),
    .bready          (bready)
  );

  typedef struct {
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ar_d;
    int          r_d;
    int          aw_d;
    int          w_d;
    int          b_d;
    logic [31:0] exp_bus;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t vecs [8];

  int errors = 0;
  int checks = 0;

  // Fabric knobs: cycles of valid before ready, or cycles from request to response.
  int ar_d, r_d, aw_d, w_d, b_d;
  bit rnd_mode;

  int          n_ar, n_aw, n_w, n_b;
  logic [31:0] last_araddr, last_awaddr;
  logic [3:0]  last_wstrb;

  logic [31:0] fab_mem [bit [29:0]];
  logic [31:0] ref_mem [bit [29:0]];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  logic [31:0] rd_q [$];
  logic [31:0] aw_q [$];
  logic [31:0] wd_q [$];
  logic [3:0]  ws_q [$];
  int          b_pend;
  int          ar_c, ar_t, aw_c, aw_t, w_c, w_t, r_c, r_t, b_c, b_t;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
  logic [31:0] s_araddr, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;

  function automatic logic [31:0] memInit(bit [29:0] w);
    return {w[13:0], w[17:0]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] fabRead(bit [29:0] k);
    return fab_mem.exists(k) ? fab_mem[k] : memInit(k);
  endfunction

  function automatic logic [31:0] refRead(bit [29:0] k);
    return ref_mem.exists(k) ? ref_mem[k] : memInit(k);
  endfunction

  function automatic int pick(int d);
    return rnd_mode ? int'($urandom_range(0, 3)) : d;
  endfunction

  function automatic int expStall(vec_t v);
    int m;
    m = (v.aw_d > v.w_d) ? v.aw_d : v.w_d;
    if (v.wen == 4'b0000) return 3 + v.ar_d + v.r_d;
`ifdef SRAM_RESP_POSTED_WRITE_EN
    return 2 + m;
`else
    return 3 + m + v.b_d;
`endif
  endfunction

  // Memory-backed fabric: acts on falling edges, detects handshakes from the values seen at the previous one.
  initial begin
    logic [31:0] tmp;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 1'b0; rvalid = 1'b0; rdata = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        rd_q.delete(); aw_q.delete(); wd_q.delete(); ws_q.delete();
        b_pend = 0; ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
        s_arvalid = 1'b0; s_rready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
      end else begin
        if (s_arvalid && arready) begin
          rd_q.push_back(s_araddr); last_araddr = s_araddr; n_ar++;
        end
        if (rvalid && s_rready) begin
          rvalid = 1'b0; void'(rd_q.pop_front());
        end
        if (s_awvalid && awready) begin
          aw_q.push_back(s_awaddr); last_awaddr = s_awaddr; n_aw++;
        end
        if (s_wvalid && wready) begin
          wd_q.push_back(s_wdata); ws_q.push_back(s_wstrb); last_wstrb = s_wstrb; n_w++;
        end
        while (aw_q.size() > 0 && wd_q.size() > 0) begin
          tmp = aw_q.pop_front();
          fab_mem[tmp[31:2]] = merge(fabRead(tmp[31:2]), wd_q.pop_front(), ws_q.pop_front());
          b_pend++;
        end
        if (bvalid && s_bready) begin
          bvalid = 1'b0; b_pend--; n_b++;
        end
        if (!rvalid && rd_q.size() > 0) begin
          if (r_c == 0) r_t = pick(r_d);
          if (r_c >= r_t) begin
            tmp = rd_q[0]; rvalid = 1'b1; rdata = fabRead(tmp[31:2]); r_c = 0;
          end else r_c++;
        end else if (!rvalid) rdata = $urandom;
        if (!bvalid && b_pend > 0) begin
          if (b_c == 0) b_t = pick(b_d);
          if (b_c >= b_t) begin
            bvalid = 1'b1; b_c = 0;
          end else b_c++;
        end
        if (arvalid) begin
          if (ar_c == 0) ar_t = pick(ar_d);
          arready = (ar_c >= ar_t); ar_c++;
        end else begin
          ar_c = 0; arready = rnd_mode && ($urandom_range(0, 1) == 1);
        end
        if (awvalid) begin
          if (aw_c == 0) aw_t = pick(aw_d);
          awready = (aw_c >= aw_t); aw_c++;
        end else begin
          aw_c = 0; awready = rnd_mode && ($urandom_range(0, 1) == 1);
        end
        if (wvalid) begin
          if (w_c == 0) w_t = pick(w_d);
          wready = (w_c >= w_t); w_c++;
        end else begin
          w_c = 0; wready = rnd_mode && ($urandom_range(0, 1) == 1);
        end
        s_arvalid = arvalid; s_araddr = araddr; s_rready = rready;
        s_awvalid = awvalid; s_awaddr = awaddr; s_wvalid = wvalid;
        s_wdata = wdata; s_wstrb = wstrb; s_bready = bready;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one CPU request, holds it while stalled, then compares data_sram_rdata against the scoreboard.
  task automatic applyStimulus(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                               input bit hold, output int stall);
    logic [31:0] exp;
    int guard;
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = wen; data_sram_addr = addr; data_sram_wdata = wd;
    if (wen == 4'b0000) begin
      exp = refRead(addr[31:2]); last_rd = exp;
    end else begin
      ref_mem[addr[31:2]] = merge(refRead(addr[31:2]), wd, wen); exp = last_rd;
    end
    exp_q.push_back(exp);
    stall = 0; guard = 0;
    #1;
    while (dataStall && guard < 200) begin
      stall++; guard++;
      @(negedge clk); #1;
    end
    if (dataStall) checkOutput("stall_timeout", 32'(dataStall), 32'd0);
    exp = exp_q.pop_front();
    checkOutput("rdata", data_sram_rdata, exp);
    if (!hold) data_sram_en = 1'b0;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int stall, guard, n0, n1, n2, n3;
    logic [31:0] a;
    logic [3:0] wen_r;

    vecs[0] = '{4'b0000, 32'h1FC0_0004, 32'h0000_0000, 0, 0, 0, 0, 0, 32'h1FC0_0004, 4'b0000};
    vecs[1] = '{4'b0011, 32'h8000_0002, 32'h1234_5678, 0, 0, 0, 2, 0, 32'h8000_0000, 4'b0011};
    vecs[2] = '{4'b0000, 32'h8000_0003, 32'h0000_0000, 1, 1, 0, 0, 0, 32'h8000_0000, 4'b0000};
    vecs[3] = '{4'b1111, 32'h0000_0010, 32'hCAFE_F00D, 0, 0, 2, 0, 1, 32'h0000_0010, 4'b1111};
    vecs[4] = '{4'b1000, 32'h0000_0011, 32'hAA00_0000, 0, 0, 1, 1, 0, 32'h0000_0010, 4'b1000};
    vecs[5] = '{4'b0000, 32'h0000_0012, 32'h0000_0000, 0, 3, 0, 0, 0, 32'h0000_0010, 4'b0000};
    vecs[6] = '{4'b0100, 32'h0000_0020, 32'h0077_0000, 0, 0, 0, 0, 0, 32'h0000_0020, 4'b0100};
    vecs[7] = '{4'b0000, 32'h0000_0020, 32'h0000_0000, 3, 0, 0, 0, 0, 32'h0000_0020, 4'b0000};

    fab_mem[30'h07F0_0001] = 32'hDEAD_BEEF;
    ref_mem[30'h07F0_0001] = 32'hDEAD_BEEF;
    last_rd = '0;
    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0; rnd_mode = 1'b0;
    n_ar = 0; n_aw = 0; n_w = 0; n_b = 0;
    resetn = 1'b0; pipelineStall = 1'b0;
    data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_rready", 32'(rready), 32'd0);
    checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
    checkOutput("rst_bready", 32'(bready), 32'd0);
    checkOutput("rst_rdata", data_sram_rdata, 32'd0);
    checkOutput("rst_stall", 32'(dataStall), 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    checkOutput("rst_awaddr", awaddr, 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_wstrb", 32'(wstrb), 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      ar_d = vecs[i].ar_d; r_d = vecs[i].r_d; aw_d = vecs[i].aw_d; w_d = vecs[i].w_d; b_d = vecs[i].b_d;
      n0 = n_ar; n1 = n_aw; n2 = n_w; n3 = n_b;
      applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, 1'b0, stall);
      checkOutput($sformatf("v%0d_stall", i), stall, expStall(vecs[i]));
      if (vecs[i].wen == 4'b0000) begin
        checkOutput($sformatf("v%0d_araddr", i), last_araddr, vecs[i].exp_bus);
        checkOutput($sformatf("v%0d_ar_count", i), n_ar - n0, 32'd1);
        checkOutput($sformatf("v%0d_aw_count", i), n_aw - n1, 32'd0);
      end else begin
        checkOutput($sformatf("v%0d_awaddr", i), last_awaddr, vecs[i].exp_bus);
        checkOutput($sformatf("v%0d_wstrb", i), 32'(last_wstrb), 32'(vecs[i].exp_strb));
        checkOutput($sformatf("v%0d_aw_count", i), n_aw - n1, 32'd1);
        checkOutput($sformatf("v%0d_w_count", i), n_w - n2, 32'd1);
        checkOutput($sformatf("v%0d_ar_count", i), n_ar - n0, 32'd0);
`ifndef SRAM_RESP_POSTED_WRITE_EN
        checkOutput($sformatf("v%0d_b_count", i), n_b - n3, 32'd1);
`endif
      end
    end

    ar_d = 0; r_d = 0; aw_d = 0; w_d = 0; b_d = 0;
    n0 = n_ar;
    applyStimulus(4'b0000, 32'h1FC0_0004, 32'h0, 1'b1, stall);
    pipelineStall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("pstall_stall_c%0d", c), 32'(dataStall), 32'd0);
      checkOutput($sformatf("pstall_rdata_c%0d", c), data_sram_rdata, 32'hDEAD_BEEF);
    end
    pipelineStall = 1'b0; data_sram_en = 1'b0;
    @(negedge clk); #1;
    checkOutput("pstall_ar_count", n_ar - n0, 32'd1);
    checkOutput("pstall_idle_stall", 32'(dataStall), 32'd0);

`ifdef SRAM_RESP_POSTED_WRITE_EN
    b_d = 4; n3 = n_b;
    applyStimulus(4'b1111, 32'h0000_0100, 32'h0BAD_F00D, 1'b0, stall);
    checkOutput("posted_wr_stall", stall, 32'd2);
    checkOutput("posted_wr_b_before", n_b - n3, 32'd0);
    applyStimulus(4'b0000, 32'h0000_0100, 32'h0, 1'b0, stall);
    checkOutput("posted_rd_stall", stall, 32'd6);
    checkOutput("posted_rd_b_after", n_b - n3, 32'd1);
    b_d = 0;
`endif

    ar_d = 0; r_d = 8;
    @(negedge clk);
    data_sram_en = 1'b1; data_sram_wen = 4'b0000; data_sram_addr = 32'h0000_0040;
    guard = 0;
    #1;
    while (!rready && guard < 20) begin
      guard++;
      @(negedge clk); #1;
    end
    checkOutput("midrst_reached_rd_data", 32'(rready), 32'd1);
    #1 data_sram_en = 1'b0; resetn = 1'b0;
    #1;
    checkOutput("midrst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("midrst_rready", 32'(rready), 32'd0);
    checkOutput("midrst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("midrst_wvalid", 32'(wvalid), 32'd0);
    checkOutput("midrst_bready", 32'(bready), 32'd0);
    checkOutput("midrst_stall", 32'(dataStall), 32'd0);
    checkOutput("midrst_rdata", data_sram_rdata, 32'd0);
    @(negedge clk);
    #2 resetn = 1'b1;
    last_rd = '0; r_d = 0;
    applyStimulus(4'b0000, 32'h1FC0_0004, 32'h0, 1'b0, stall);
    checkOutput("midrst_next_stall", stall, 32'd3);

    rnd_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      a = 32'h0000_4000 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wen_r = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      applyStimulus(wen_r, a, $urandom, 1'b0, stall);
    end
    rnd_mode = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_data_responder.md
# sram_data_responder

Responder end of the CPU data-side SRAM-like port. It accepts the single-cycle-valid `data_sram_*` request driven by the CPU core and turns it into one AXI4-Lite-style read or write transaction. It holds `dataStall` high until the transaction completes, then returns read data on `data_sram_rdata`. It sits between the CPU's data SRAM port and the memory/bus fabric, in place of a data cache.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte strobes are DATA_W/8 = 4

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- data_sram_en  in  1  request valid; held by CPU while stalled
- data_sram_wen  in  4  byte write enables; 0 = read
- data_sram_addr  in  32  physical byte address
- data_sram_wdata  in  32  write data
- data_sram_rdata  out  32  read data, registered
- dataStall  out  1  stall request to the CPU
- pipelineStall  in  1  CPU-wide stall, from any source
- araddr  out  32  /  arvalid  out  1  /  arready  in  1  read address channel
- rdata  in  32  /  rvalid  in  1  /  rready  out  1  read data channel
- awaddr  out  32  /  awvalid  out  1  /  awready  in  1  write address channel
- wdata  out  32  /  wstrb  out  4  /  wvalid  out  1  /  wready  in  1  write data channel
- bvalid  in  1  /  bready  out  1  write response channel

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE with data_sram_en=1:
  - Latch addr, wen and wdata.
  - Go to RD_ADDR if wen==0, otherwise WR_REQ.
- RD_ADDR:
  - arvalid=1 and araddr={addr[31:2],2'b00}, both stable until arready.
  - On arready, go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, capture rdata into data_sram_rdata and go to DONE.
- WR_REQ:
  - awvalid and wvalid are raised together. awaddr={addr[31:2],2'b00}, wdata=latched wdata, wstrb=latched wen.
  - Each valid drops independently after its own handshake; aw_done and w_done flags record them.
  - When both handshakes are done (including both in the same cycle), go to WR_RESP.
- WR_RESP:
  - bready=1.
  - On bvalid, go to DONE. bresp is ignored.
- DONE:
  - dataStall=0 and the request is considered consumed.
  - If pipelineStall=1, stay in DONE holding data_sram_rdata, so a held request is not reissued.
  - Otherwise go to IDLE.
- dataStall = (IDLE & data_sram_en) | (state ∉ {IDLE, DONE}). This is combinational.
- data_sram_rdata holds its last value until the next read completes; writes do not alter it.
- Only one transaction is outstanding at a time. Reads and writes are never overlapped.

## Timing
- Reset values: state=IDLE, all valids 0, rready=0, bready=0, data_sram_rdata=0, dataStall=0 (or equal to data_sram_en), address/data/strb outputs 0.
- Reset mid-transaction aborts immediately. No channel valid is held after reset; the fabric must also be reset.
- Read latency with zero-wait fabric:
  - Request seen in cycle 0 (IDLE) → arvalid in cycle 1 → rvalid accepted in cycle 2.
  - DONE in cycle 3, where dataStall=0.
- Write latency with zero-wait fabric: aw/w in cycle 1 → bvalid in cycle 2 → DONE in cycle 3.
- A new request is sampled no earlier than the cycle after DONE exits.
- Valid signals never depend combinationally on ready.

## Configuration
- SRAM_RESP_POSTED_WRITE_EN defined:
  - WR_REQ goes directly to DONE once both aw and w handshakes are done.
  - The wr_pending flag sets, with bready=1 while pending. bvalid clears it.
  - In IDLE, any request arriving while wr_pending=1 stalls and stays in IDLE until bvalid. A bvalid in the same cycle allows the request to launch next cycle.
- Undefined: writes wait in WR_RESP as described above. wr_pending logic is absent.

## Test plan
- Read, zero-wait: addr=0x1FC0_0004, rdata=0xDEADBEEF → araddr=0x1FC0_0004, dataStall high for 3 cycles, then data_sram_rdata=0xDEADBEEF.
- Write with aw ready 2 cycles before w: wen=4'b0011, wdata=0x12345678, addr=0x8000_0002 → awaddr=0x8000_0000, wstrb=0011, one aw and one w handshake each, stall until bvalid+1.
- DONE under pipelineStall=1 for 4 cycles → exactly one ar handshake, rdata held, dataStall=0 throughout DONE.
- Back-to-back read after write, with macro defined: write stall ends before bvalid; the read stays stalled in IDLE until bvalid, then arvalid.
- resetn low during RD_DATA → all valids 0 and state IDLE asynchronously; after reset, the next request is issued normally.
- Random ready/valid backpressure over 1000 mixed requests → memory-model scoreboard matches every read.
